// File: rtl/mdr_queued.sv
// Memory data register: DEPTH-entry store FIFO toward memory plus a single-entry
// load holding register toward the bus with sticky overrun detection.
module mdr_queued #(
  parameter  int DATA_W = 18,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bus_wr_valid,
  output logic              bus_wr_ready,
  input  logic [DATA_W-1:0] bus_wr_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              bus_rd_valid,
  input  logic              bus_rd_ready,
  output logic [DATA_W-1:0] bus_rd_data,
  input  logic              clr_ovr,
  output logic [CNT_W-1:0]  wq_count,
  output logic              wq_full,
  output logic              wq_empty,
  output logic              rd_overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rvld_q, rvld_d, ovr_q, ovr_d;
  logic              push, pop, consume;

  assign wq_full      = (cnt_q == CNT_W'(DEPTH));
  assign wq_empty     = (cnt_q == '0);
  assign wq_count     = cnt_q;
  assign bus_wr_ready = !wq_full;
  assign mem_wr_valid = !wq_empty;
  assign mem_wr_data  = mem_q[rptr_q];
  assign bus_rd_valid = rvld_q;
  assign bus_rd_data  = rdat_q;
  assign rd_overrun   = ovr_q;

  // Flush overrides any handshake in the same cycle.
  assign push    = bus_wr_valid && bus_wr_ready && !flush;
  assign pop     = mem_wr_valid && mem_wr_ready && !flush;
  assign consume = rvld_q && bus_rd_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    rdat_d = rdat_q;
    rvld_d = rvld_q;
    ovr_d  = ovr_q;
    if (mem_rd_valid) begin
      rdat_d = mem_rd_data;
      rvld_d = 1'b1;
    end else if (consume) begin
      rvld_d = 1'b0;
    end
    // A new overrun beats a clear arriving in the same cycle.
    if (mem_rd_valid && rvld_q && !bus_rd_ready) ovr_d = 1'b1;
    else if (clr_ovr)                            ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rdat_q <= '0;
      rvld_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rdat_q <= rdat_d;
      rvld_q <= rvld_d;
      ovr_q  <= ovr_d;
    end
  end

  // Queue storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus_wr_data;
  end
endmodule

// File: doc/mdr_queued.md
Name: mdr_queued

Overview:
- Parametrised memory data register for the processor datapath, placed between the internal bus and the memory port.
- Bus-to-memory direction: a DEPTH-entry write FIFO that absorbs bus stores while memory is busy.
- Memory-to-bus direction: a single-entry read holding register with a valid/ready handshake and sticky overrun detection.
- Replaces the tristate-output MDR with explicit handshakes and status outputs.

Parameters:
- DATA_W, 18, data word width on both sides.
- DEPTH, 4, write-queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the write queue.
- bus_wr_valid  in  1  bus offers a store word.
- bus_wr_ready  out  1  queue can accept a word.
- bus_wr_data  in  DATA_W  store word from the bus.
- mem_wr_valid  out  1  queue head is valid toward memory.
- mem_wr_ready  in  1  memory accepts the head word.
- mem_wr_data  out  DATA_W  queue head word.
- mem_rd_valid  in  1  one-cycle pulse: memory returns load data.
- mem_rd_data  in  DATA_W  load data from memory.
- bus_rd_valid  out  1  read holding register is full.
- bus_rd_ready  in  1  bus consumes the held word.
- bus_rd_data  out  DATA_W  held load word.
- clr_ovr  in  1  clears rd_overrun.
- wq_count  out  CNT_W  write-queue occupancy, 0..DEPTH.
- wq_full  out  1  wq_count == DEPTH.
- wq_empty  out  1  wq_count == 0.
- rd_overrun  out  1  sticky flag: unconsumed load data was overwritten.

Behaviour:
- Reset (rst low, asynchronous):
  - Write and read pointers, wq_count, bus_rd_valid, bus_rd_data and rd_overrun all go to 0.
  - Queue storage is not cleared.
  - Resulting outputs: bus_wr_ready=1, wq_empty=1, mem_wr_valid=0.
  - Reset mid-transfer discards all queued and held data; no handshake completes in the reset cycle.
- Write queue:
  - Push: bus_wr_valid && bus_wr_ready. Pop: mem_wr_valid && mem_wr_ready.
  - bus_wr_ready = !wq_full. There is no same-cycle pass-through when full, even if a pop occurs that cycle.
  - mem_wr_valid = !wq_empty. mem_wr_data is driven combinationally from the head entry.
  - Latency: a word pushed in cycle N is visible at mem_wr_data in cycle N+1.
  - Push and pop in the same cycle: both occur and wq_count is unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Order is strictly FIFO.
- Flush:
  - Clears the pointers and wq_count next edge. Any push or pop in that cycle is ignored.
  - Has no effect on the read path.
- Read holding register:
  - mem_rd_valid loads mem_rd_data next edge and sets bus_rd_valid.
  - A consume (bus_rd_valid && bus_rd_ready) with no load clears bus_rd_valid.
  - Consume and load in the same cycle: the new word is latched, bus_rd_valid stays 1, rd_overrun does not change.
  - Load while bus_rd_valid=1 and no consume: the word is overwritten with the new data and rd_overrun is set.
  - rd_overrun holds until clr_ovr. If clr_ovr and a new overrun coincide, set wins.
  - bus_rd_data holds its value when not loading and is never driven to Z.
- Status outputs: wq_count, wq_full and wq_empty are registered or derived from registered state only, with no combinational path from the inputs.
- Handshake rules:
  - Outputs must not depend combinationally on the same-cycle ready inputs, except that pop/consume take effect at the next edge.
  - bus_wr_data is sampled only on a push.

Test Plan:
- Reset then idle, DATA_W=18, DEPTH=4 -> wq_count=0, wq_empty=1, bus_wr_ready=1, bus_rd_valid=0, rd_overrun=0.
- Push 0x00001, 0x00002, 0x00003, 0x00004 with mem_wr_ready=0 -> wq_full=1, bus_wr_ready=0, wq_count=4. Then set mem_wr_ready=1 -> mem_wr_data sequence 1, 2, 3, 4, then wq_empty=1.
- Queue holding 2 words, simultaneous push 0x3FFFF and pop for 6 cycles -> wq_count stays 2 and output order is preserved across pointer wrap.
- mem_rd_valid with 0x12345, bus_rd_ready=0, then mem_rd_valid with 0x0ABCD -> bus_rd_data=0x0ABCD, rd_overrun=1. Pulse clr_ovr -> rd_overrun=0.
- Consume and load in the same cycle (0x00055) -> bus_rd_valid remains 1, bus_rd_data=0x00055, rd_overrun=0.
- With 3 queued words, assert flush together with a push -> wq_count=0 next cycle. Then assert rst low mid-read -> bus_rd_valid=0 immediately, without waiting for clk.
